mips_multicycle_ctrl: RTL and testbench

Main control FSM for the multi-cycle MIPS datapath. It sequences fetch, decode, execute, memory and write-back, and drives every datapath select and enable. This includes the 2-bit write-register select for the rt/rd/$31 destination mux and the 2-bit write-data select. It sits between the instruction register (opcode/funct) and the datapath muxes, register file, memory and PC.

---
 rtl/mips_multicycle_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences fetch/decode/execute/
// memory/write-back and drives every datapath select and enable.
module mips_multicycle_ctrl #(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               pc_write,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic [1:0]         reg_dst_sel,
    output logic [1:0]         mem_to_reg_sel,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_src,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11,
        S_JAL     = 4'd12,
        S_JR      = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    state_t state_q;
    state_t state_d;
    state_t decode_next;
    logic   decode_ill;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Dispatch from DECODE; anything unsupported retires immediately as illegal.
    always_comb begin
        decode_next = S_FETCH;
        decode_ill  = 1'b0;
        case (opcode)
            OP_LW, OP_SW:    decode_next = S_MEMADR;
            OP_BEQ, OP_BNE:  decode_next = S_BRANCH;
            OP_ADDI:         decode_next = S_ADDI_EX;
            OP_J:            decode_next = S_JUMP;
            OP_JAL:          decode_next = S_JAL;
            OP_RTYPE: begin
                case (funct)
                    FN_JR:                                  decode_next = S_JR;
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT:  decode_next = S_EXEC;
                    default:                                decode_ill  = 1'b1;
                endcase
            end
            default:         decode_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE:  state_d = decode_next;
            S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXEC:    state_d = S_ALUWB;
            S_ADDI_EX: state_d = S_ADDI_WB;
            default:   state_d = S_FETCH;
        endcase
    end

    // Outputs are held at zero while rst is high so no partial strobe escapes.
    always_comb begin
        pc_write       = 1'b0;
        iord           = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        ir_write       = 1'b0;
        reg_write      = 1'b0;
        reg_dst_sel    = 2'b00;
        mem_to_reg_sel = 2'b00;
        alu_src_a      = 1'b0;
        alu_src_b      = 2'b00;
        alu_op         = 2'b00;
        pc_src         = 2'b00;
        instr_done     = 1'b0;
        illegal_op     = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    ir_write  = 1'b1;
                    alu_src_b = 2'b01;
                    pc_write  = 1'b1;
                end
                S_DECODE: begin
                    alu_src_b  = 2'b11;
                    illegal_op = decode_ill;
                    instr_done = decode_ill;
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                end
                S_MEMWB: begin
                    reg_write      = 1'b1;
                    reg_dst_sel    = 2'b00;
                    mem_to_reg_sel = 2'b01;
                    instr_done     = 1'b1;
                end
                S_MEMWR: begin
                    iord       = 1'b1;
                    mem_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b00;
                    alu_op    = 2'b10;
                end
                S_ALUWB: begin
                    reg_write      = 1'b1;
                    reg_dst_sel    = 2'b01;
                    mem_to_reg_sel = 2'b00;
                    instr_done     = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_op     = 2'b01;
                    pc_src     = 2'b01;
                    instr_done = 1'b1;
                    pc_write   = ((opcode == OP_BEQ) &&  zero) ||
                                 ((opcode == OP_BNE) && !zero);
                end
                S_ADDI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = 2'b00;
                end
                S_ADDI_WB: begin
                    reg_write   = 1'b1;
                    reg_dst_sel = 2'b00;
                    instr_done  = 1'b1;
                end
                S_JUMP: begin
                    pc_src     = 2'b10;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                end
                S_JAL: begin
                    reg_write      = 1'b1;
                    reg_dst_sel    = 2'b10;
                    mem_to_reg_sel = 2'b10;
                    pc_src         = 2'b10;
                    pc_write       = 1'b1;
                    instr_done     = 1'b1;
                end
                S_JR: begin
                    pc_src     = 2'b11;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state = rst ? '0 : STATE_W'(state_q);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed self-checking bench for mips_multicycle_ctrl: walks each instruction class
// cycle by cycle and compares state and the full control word against hand-built values.
module tb_mips_multicycle_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_write, iord, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] reg_dst_sel, mem_to_reg_sel, alu_src_b, alu_op, pc_src;
    logic       alu_src_a, instr_done, illegal_op;
    logic [3:0] state;

    int unsigned checks;
    int unsigned failures;

    mips_multicycle_ctrl #(.STATE_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .opcode         (opcode),
        .funct          (funct),
        .zero           (zero),
        .pc_write       (pc_write),
        .iord           (iord),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .ir_write       (ir_write),
        .reg_write      (reg_write),
        .reg_dst_sel    (reg_dst_sel),
        .mem_to_reg_sel (mem_to_reg_sel),
        .alu_src_a      (alu_src_a),
        .alu_src_b      (alu_src_b),
        .alu_op         (alu_op),
        .pc_src         (pc_src),
        .instr_done     (instr_done),
        .illegal_op     (illegal_op),
        .state          (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Field order: pcw iord mr mw irw rw rd[2] m2r[2] asa asb[2] aop[2] psrc[2] done ill
    function automatic logic [18:0] cw(input logic pcw, input logic io, input logic mr,
                                       input logic mw, input logic irw, input logic rw,
                                       input logic [1:0] rd, input logic [1:0] m2r,
                                       input logic asa, input logic [1:0] asb,
                                       input logic [1:0] aop, input logic [1:0] psrc,
                                       input logic done, input logic ill);
        return {pcw, io, mr, mw, irw, rw, rd, m2r, asa, asb, aop, psrc, done, ill};
    endfunction

    function automatic logic [18:0] dut_cw();
        return {pc_write, iord, mem_read, mem_write, ir_write, reg_write, reg_dst_sel,
                mem_to_reg_sel, alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal_op};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Called at a negedge; checks settled outputs, then advances to the next negedge.
    task automatic step(input string tag, input logic [3:0] st, input logic [18:0] exp_cw);
        #1;
        check({tag, "_state"}, 32'(state), 32'(st));
        check({tag, "_cw"}, 32'(dut_cw()), 32'(exp_cw));
        @(negedge clk);
    endtask

    logic [18:0] CW_FETCH, CW_DECODE, CW_DEC_ILL, CW_MEMADR, CW_MEMRD, CW_MEMWB, CW_MEMWR;
    logic [18:0] CW_EXEC, CW_ALUWB, CW_BR_T, CW_BR_N, CW_ADDI_EX, CW_ADDI_WB;
    logic [18:0] CW_JUMP, CW_JAL, CW_JR;

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        opcode = op;
        funct  = fn;
        zero   = z;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        CW_FETCH   = cw(1,0,1,0,1,0,2'd0,2'd0,0,2'd1,2'd0,2'd0,0,0);
        CW_DECODE  = cw(0,0,0,0,0,0,2'd0,2'd0,0,2'd3,2'd0,2'd0,0,0);
        CW_DEC_ILL = cw(0,0,0,0,0,0,2'd0,2'd0,0,2'd3,2'd0,2'd0,1,1);
        CW_MEMADR  = cw(0,0,0,0,0,0,2'd0,2'd0,1,2'd2,2'd0,2'd0,0,0);
        CW_MEMRD   = cw(0,1,1,0,0,0,2'd0,2'd0,0,2'd0,2'd0,2'd0,0,0);
        CW_MEMWB   = cw(0,0,0,0,0,1,2'd0,2'd1,0,2'd0,2'd0,2'd0,1,0);
        CW_MEMWR   = cw(0,1,0,1,0,0,2'd0,2'd0,0,2'd0,2'd0,2'd0,1,0);
        CW_EXEC    = cw(0,0,0,0,0,0,2'd0,2'd0,1,2'd0,2'd2,2'd0,0,0);
        CW_ALUWB   = cw(0,0,0,0,0,1,2'd1,2'd0,0,2'd0,2'd0,2'd0,1,0);
        CW_BR_T    = cw(1,0,0,0,0,0,2'd0,2'd0,1,2'd0,2'd1,2'd1,1,0);
        CW_BR_N    = cw(0,0,0,0,0,0,2'd0,2'd0,1,2'd0,2'd1,2'd1,1,0);
        CW_ADDI_EX = cw(0,0,0,0,0,0,2'd0,2'd0,1,2'd2,2'd0,2'd0,0,0);
        CW_ADDI_WB = cw(0,0,0,0,0,1,2'd0,2'd0,0,2'd0,2'd0,2'd0,1,0);
        CW_JUMP    = cw(1,0,0,0,0,0,2'd0,2'd0,0,2'd0,2'd0,2'd2,1,0);
        CW_JAL     = cw(1,0,0,0,0,1,2'd2,2'd2,0,2'd0,2'd0,2'd2,1,0);
        CW_JR      = cw(1,0,0,0,0,0,2'd0,2'd0,0,2'd0,2'd0,2'd3,1,0);

        rst = 1'b1;
        set_instr(6'h00, 6'h00, 1'b0);
        @(negedge clk);
        step("rst0", 4'd0, 19'd0);
        step("rst1", 4'd0, 19'd0);
        rst = 1'b0;

        // lw interrupted by reset in MEMRD
        set_instr(6'h23, 6'h00, 1'b0);
        step("lwi_f", 4'd0, CW_FETCH);
        step("lwi_d", 4'd1, CW_DECODE);
        step("lwi_a", 4'd2, CW_MEMADR);
        #1;
        check("lwi_memrd_state", 32'(state), 32'd3);
        rst = 1'b1;
        step("midrst0", 4'd0, 19'd0);
        step("midrst1", 4'd0, 19'd0);
        rst = 1'b0;

        // lw
        step("lw_f", 4'd0, CW_FETCH);
        step("lw_d", 4'd1, CW_DECODE);
        step("lw_a", 4'd2, CW_MEMADR);
        step("lw_r", 4'd3, CW_MEMRD);
        step("lw_wb", 4'd4, CW_MEMWB);

        // sw
        set_instr(6'h2B, 6'h00, 1'b0);
        step("sw_f", 4'd0, CW_FETCH);
        step("sw_d", 4'd1, CW_DECODE);
        step("sw_a", 4'd2, CW_MEMADR);
        step("sw_w", 4'd5, CW_MEMWR);

        // R-type add
        set_instr(6'h00, 6'h20, 1'b0);
        step("add_f", 4'd0, CW_FETCH);
        step("add_d", 4'd1, CW_DECODE);
        step("add_x", 4'd6, CW_EXEC);
        step("add_wb", 4'd7, CW_ALUWB);

        // R-type slt (last supported ALU funct)
        set_instr(6'h00, 6'h2A, 1'b0);
        step("slt_f", 4'd0, CW_FETCH);
        step("slt_d", 4'd1, CW_DECODE);
        step("slt_x", 4'd6, CW_EXEC);
        step("slt_wb", 4'd7, CW_ALUWB);

        // jr
        set_instr(6'h00, 6'h08, 1'b0);
        step("jr_f", 4'd0, CW_FETCH);
        step("jr_d", 4'd1, CW_DECODE);
        step("jr_x", 4'd13, CW_JR);

        // jal
        set_instr(6'h03, 6'h00, 1'b0);
        step("jal_f", 4'd0, CW_FETCH);
        step("jal_d", 4'd1, CW_DECODE);
        step("jal_x", 4'd12, CW_JAL);

        // j
        set_instr(6'h02, 6'h00, 1'b0);
        step("j_f", 4'd0, CW_FETCH);
        step("j_d", 4'd1, CW_DECODE);
        step("j_x", 4'd9, CW_JUMP);

        // addi
        set_instr(6'h08, 6'h00, 1'b0);
        step("addi_f", 4'd0, CW_FETCH);
        step("addi_d", 4'd1, CW_DECODE);
        step("addi_x", 4'd10, CW_ADDI_EX);
        step("addi_wb", 4'd11, CW_ADDI_WB);

        // branches: beq z=1 taken, beq z=0 not, bne z=0 taken, bne z=1 not
        set_instr(6'h04, 6'h00, 1'b1);
        step("beq1_f", 4'd0, CW_FETCH);
        step("beq1_d", 4'd1, CW_DECODE);
        step("beq1_b", 4'd8, CW_BR_T);
        set_instr(6'h04, 6'h00, 1'b0);
        step("beq0_f", 4'd0, CW_FETCH);
        step("beq0_d", 4'd1, CW_DECODE);
        step("beq0_b", 4'd8, CW_BR_N);
        set_instr(6'h05, 6'h00, 1'b0);
        step("bne0_f", 4'd0, CW_FETCH);
        step("bne0_d", 4'd1, CW_DECODE);
        step("bne0_b", 4'd8, CW_BR_T);
        set_instr(6'h05, 6'h00, 1'b1);
        step("bne1_f", 4'd0, CW_FETCH);
        step("bne1_d", 4'd1, CW_DECODE);
        step("bne1_b", 4'd8, CW_BR_N);

        // illegal opcode, then illegal R-type funct
        set_instr(6'h3F, 6'h00, 1'b0);
        step("ill_f", 4'd0, CW_FETCH);
        step("ill_d", 4'd1, CW_DEC_ILL);
        set_instr(6'h00, 6'h21, 1'b0);
        step("illfn_f", 4'd0, CW_FETCH);
        step("illfn_d", 4'd1, CW_DEC_ILL);
        step("after_ill_f", 4'd0, CW_FETCH);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
